// File: rtl/dfe_coeff_load_ctrl_if.sv
// Host config / DFE core coefficient port bundle for dfe_coeff_load_ctrl.
// Optional readback signals exist only when DFE_COEFF_READBACK_CHECK_EN is defined.
interface dfe_coeff_load_ctrl_if #(
    parameter int unsigned COEFF_WIDTH = 20,
    parameter int unsigned FRAC_N_TAP  = 146,
    parameter int unsigned IIR_DEPTH   = 5
);
    logic                   cfg_start;
    logic [1:0]             cfg_target;
    logic                   cfg_abort;
    logic                   cfg_valid;
    logic [COEFF_WIDTH-1:0] cfg_data;
    logic                   cfg_ready;
    logic                   sample_valid;
    logic [COEFF_WIDTH-1:0] frac_coeff [FRAC_N_TAP];
    logic [COEFF_WIDTH-1:0] iir1_coeff [IIR_DEPTH];
    logic [COEFF_WIDTH-1:0] iir2_coeff [IIR_DEPTH];
    logic                   frac_wr_en;
    logic                   iir1_wr_en;
    logic                   iir2_wr_en;
    logic                   busy;
    logic                   done;
    logic                   cfg_err;
`ifdef DFE_COEFF_READBACK_CHECK_EN
    logic [COEFF_WIDTH-1:0] frac_coeff_rb [FRAC_N_TAP];
    logic [COEFF_WIDTH-1:0] iir1_coeff_rb [IIR_DEPTH];
    logic [COEFF_WIDTH-1:0] iir2_coeff_rb [IIR_DEPTH];
    logic                   chk_err;
`endif

    // Host / core side
    modport master (
        output cfg_start, cfg_target, cfg_abort, cfg_valid, cfg_data, sample_valid,
`ifdef DFE_COEFF_READBACK_CHECK_EN
        output frac_coeff_rb, iir1_coeff_rb, iir2_coeff_rb,
        input  chk_err,
`endif
        input  cfg_ready, frac_coeff, iir1_coeff, iir2_coeff,
        input  frac_wr_en, iir1_wr_en, iir2_wr_en, busy, done, cfg_err
    );

    // Load controller side
    modport slave (
        input  cfg_start, cfg_target, cfg_abort, cfg_valid, cfg_data, sample_valid,
`ifdef DFE_COEFF_READBACK_CHECK_EN
        input  frac_coeff_rb, iir1_coeff_rb, iir2_coeff_rb,
        output chk_err,
`endif
        output cfg_ready, frac_coeff, iir1_coeff, iir2_coeff,
        output frac_wr_en, iir1_wr_en, iir2_wr_en, busy, done, cfg_err
    );
endinterface

// File: rtl/dfe_coeff_load_ctrl.sv
// DFE coefficient load controller: collects a coefficient stream into per-target
// shadow registers and commits it with a single write strobe in a sample gap.
// Optional feature macro: DFE_COEFF_READBACK_CHECK_EN (adds a VERIFY state and chk_err).
module dfe_coeff_load_ctrl #(
    parameter int unsigned COEFF_WIDTH = 20,
    parameter int unsigned FRAC_N_TAP  = 146,
    parameter int unsigned IIR_DEPTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    dfe_coeff_load_ctrl_if.slave  cif
);
    localparam int unsigned IDX_W     = $clog2(FRAC_N_TAP);
    localparam int unsigned IIR_IDX_W = $clog2(IIR_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_DONE
`ifdef DFE_COEFF_READBACK_CHECK_EN
        , S_VERIFY
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [1:0]             tgt_q, tgt_d;
    logic                   cfg_ready_q, cfg_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   frac_wr_q, frac_wr_d;
    logic                   iir1_wr_q, iir1_wr_d;
    logic                   iir2_wr_q, iir2_wr_d;
    logic                   hs;
    logic                   is_last;
    logic [IDX_W-1:0]       last_idx;

    logic [COEFF_WIDTH-1:0] frac_q [FRAC_N_TAP];
    logic [COEFF_WIDTH-1:0] iir1_q [IIR_DEPTH];
    logic [COEFF_WIDTH-1:0] iir2_q [IIR_DEPTH];

`ifdef DFE_COEFF_READBACK_CHECK_EN
    logic chk_q, chk_d;
    logic rb_mismatch;
`endif

    // Accepted word this cycle; abort wins over a same-cycle handshake
    assign hs       = (state_q == S_LOAD) && cif.cfg_valid && cfg_ready_q && !cif.cfg_abort;
    assign last_idx = (tgt_q == 2'd0) ? IDX_W'(FRAC_N_TAP - 1) : IDX_W'(IIR_DEPTH - 1);
    assign is_last  = (idx_q == last_idx);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            tgt_q       <= '0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frac_wr_q   <= 1'b0;
            iir1_wr_q   <= 1'b0;
            iir2_wr_q   <= 1'b0;
`ifdef DFE_COEFF_READBACK_CHECK_EN
            chk_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tgt_q       <= tgt_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frac_wr_q   <= frac_wr_d;
            iir1_wr_q   <= iir1_wr_d;
            iir2_wr_q   <= iir2_wr_d;
`ifdef DFE_COEFF_READBACK_CHECK_EN
            chk_q       <= chk_d;
`endif
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cif.cfg_start && (cif.cfg_target != 2'd3)) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (cif.cfg_abort)      state_d = S_IDLE;
                else if (hs && is_last) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (cif.cfg_abort)          state_d = S_IDLE;
                else if (!cif.sample_valid) state_d = S_DONE;
            end
`ifdef DFE_COEFF_READBACK_CHECK_EN
            S_DONE:   state_d = S_VERIFY;
            S_VERIFY: state_d = S_IDLE;
`else
            S_DONE:   state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        idx_d       = idx_q;
        tgt_d       = tgt_q;
        cfg_ready_d = (state_d == S_LOAD);
        busy_d      = (state_d != S_IDLE);
        done_d      = 1'b0;
        err_d       = cif.cfg_start && ((state_q != S_IDLE) || (cif.cfg_target == 2'd3));
        frac_wr_d   = 1'b0;
        iir1_wr_d   = 1'b0;
        iir2_wr_d   = 1'b0;
`ifdef DFE_COEFF_READBACK_CHECK_EN
        chk_d       = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cif.cfg_start && (cif.cfg_target != 2'd3)) begin
                    tgt_d = cif.cfg_target;
                    idx_d = '0;
`ifdef DFE_COEFF_READBACK_CHECK_EN
                    chk_d = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (hs) idx_d = idx_q + IDX_W'(1);
            end
            S_COMMIT: begin
                if (!cif.cfg_abort && !cif.sample_valid) begin
                    frac_wr_d = (tgt_q == 2'd0);
                    iir1_wr_d = (tgt_q == 2'd1);
                    iir2_wr_d = (tgt_q == 2'd2);
                end
            end
`ifdef DFE_COEFF_READBACK_CHECK_EN
            S_VERIFY: begin
                done_d = 1'b1;
                if (rb_mismatch) chk_d = 1'b1;
            end
`else
            S_DONE: done_d = 1'b1;
`endif
            default: ;
        endcase
    end

    // Shadow registers: only the latched target's word at the current index moves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FRAC_N_TAP; i++) frac_q[i] <= '0;
            for (int i = 0; i < IIR_DEPTH; i++) begin
                iir1_q[i] <= '0;
                iir2_q[i] <= '0;
            end
        end else if (hs) begin
            case (tgt_q)
                2'd0:    frac_q[idx_q] <= cif.cfg_data;
                2'd1:    iir1_q[idx_q[IIR_IDX_W-1:0]] <= cif.cfg_data;
                2'd2:    iir2_q[idx_q[IIR_IDX_W-1:0]] <= cif.cfg_data;
                default: ;
            endcase
        end
    end

`ifdef DFE_COEFF_READBACK_CHECK_EN
    // Compare the committed target's readback against its shadow
    always_comb begin
        rb_mismatch = 1'b0;
        case (tgt_q)
            2'd0: for (int i = 0; i < FRAC_N_TAP; i++)
                      if (cif.frac_coeff_rb[i] != frac_q[i]) rb_mismatch = 1'b1;
            2'd1: for (int i = 0; i < IIR_DEPTH; i++)
                      if (cif.iir1_coeff_rb[i] != iir1_q[i]) rb_mismatch = 1'b1;
            2'd2: for (int i = 0; i < IIR_DEPTH; i++)
                      if (cif.iir2_coeff_rb[i] != iir2_q[i]) rb_mismatch = 1'b1;
            default: ;
        endcase
    end

    assign cif.chk_err = chk_q;
`endif

    assign cif.cfg_ready  = cfg_ready_q;
    assign cif.busy       = busy_q;
    assign cif.done       = done_q;
    assign cif.cfg_err    = err_q;
    assign cif.frac_wr_en = frac_wr_q;
    assign cif.iir1_wr_en = iir1_wr_q;
    assign cif.iir2_wr_en = iir2_wr_q;
    assign cif.frac_coeff = frac_q;
    assign cif.iir1_coeff = iir1_q;
    assign cif.iir2_coeff = iir2_q;
endmodule

// File: tb/tb_dfe_coeff_load_ctrl.sv
// Self-checking bench for dfe_coeff_load_ctrl: randomized coefficient loads checked
// against an array model of what each shadow must hold and when strobes must fire.
module tb_dfe_coeff_load_ctrl;
    localparam int unsigned CW = 20;
    localparam int unsigned NF = 146;
    localparam int unsigned NI = 5;
`ifdef DFE_COEFF_READBACK_CHECK_EN
    localparam int WR2DONE = 2;
`else
    localparam int WR2DONE = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dfe_coeff_load_ctrl_if #(.COEFF_WIDTH(CW), .FRAC_N_TAP(NF), .IIR_DEPTH(NI)) cif ();

    dfe_coeff_load_ctrl #(.COEFF_WIDTH(CW), .FRAC_N_TAP(NF), .IIR_DEPTH(NI)) dut (
        .clk (clk),
        .rst (rst),
        .cif (cif)
    );

`ifdef DFE_COEFF_READBACK_CHECK_EN
    // Targets capture their shadow on the write strobe
    always @(posedge clk) begin
        if (cif.frac_wr_en) cif.frac_coeff_rb <= cif.frac_coeff;
        if (cif.iir1_wr_en) cif.iir1_coeff_rb <= cif.iir1_coeff;
        if (cif.iir2_wr_en) cif.iir2_coeff_rb <= cif.iir2_coeff;
    end
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_wr [3];
    int wr_cyc [3];
    int n_done, done_cyc, n_err;
    int start_cyc, last_hs_cyc, drop_cyc;
    bit timed_out;

    logic [CW-1:0] exp_frac [NF];
    logic [CW-1:0] exp_i1 [NI];
    logic [CW-1:0] exp_i2 [NI];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (cif.frac_wr_en) begin n_wr[0]++; wr_cyc[0] = cyc; end
        if (cif.iir1_wr_en) begin n_wr[1]++; wr_cyc[1] = cyc; end
        if (cif.iir2_wr_en) begin n_wr[2]++; wr_cyc[2] = cyc; end
        if (cif.done)       begin n_done++;  done_cyc  = cyc; end
        if (cif.cfg_err)    n_err++;
    end

    task automatic clear_mon();
        for (int i = 0; i < 3; i++) begin n_wr[i] = 0; wr_cyc[i] = -1; end
        n_done = 0; done_cyc = -1; n_err = 0;
    endtask

    function automatic int count_diffs();
        int d = 0;
        for (int i = 0; i < NF; i++) if (cif.frac_coeff[i] !== exp_frac[i]) d++;
        for (int i = 0; i < NI; i++) begin
            if (cif.iir1_coeff[i] !== exp_i1[i]) d++;
            if (cif.iir2_coeff[i] !== exp_i2[i]) d++;
        end
        return d;
    endfunction

    // Drives one load; abort_after >= 0 aborts after that many accepted words
    task automatic run_load(input logic [1:0] tgt, input int gap_pct, input int stall,
                            input bit poke, input int abort_after, input bit seq_words);
        int depth, n, acc, guard;
        bit hs, poked;
        logic [31:0] w;
        depth = (tgt == 2'd0) ? NF : NI;
        n = (abort_after >= 0) ? abort_after : depth;
        timed_out = 1'b0;
        poked = 1'b0;
        cif.cfg_start = 1'b1;
        cif.cfg_target = tgt;
        cif.sample_valid = (stall > 0);
        start_cyc = cyc;
        @(posedge clk); #1;
        cif.cfg_start = 1'b0;
        acc = 0; guard = 0;
        while (acc < n && guard < 5000) begin
            if (poke && acc == 2 && !poked) begin
                cif.cfg_start = 1'b1;
                cif.cfg_target = 2'($urandom);
                poked = 1'b1;
            end else begin
                cif.cfg_start = 1'b0;
            end
            cif.cfg_valid = ($urandom_range(99) >= gap_pct);
            w = seq_words ? 32'(acc + 1) : $urandom;
            cif.cfg_data = w[CW-1:0];
            hs = cif.cfg_valid && cif.cfg_ready;
            @(posedge clk); #1;
            if (hs) begin
                case (tgt)
                    2'd0:    exp_frac[acc] = w[CW-1:0];
                    2'd1:    exp_i1[acc]   = w[CW-1:0];
                    default: exp_i2[acc]   = w[CW-1:0];
                endcase
                acc++;
                last_hs_cyc = cyc;
            end
            guard++;
        end
        if (guard >= 5000) timed_out = 1'b1;
        cif.cfg_start = 1'b0;
        cif.cfg_valid = 1'b0;
        if (abort_after >= 0) begin
            w = $urandom;
            cif.cfg_abort = 1'b1;
            cif.cfg_valid = 1'b1;
            cif.cfg_data = w[CW-1:0];
            @(posedge clk); #1;
            cif.cfg_abort = 1'b0;
            cif.cfg_valid = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
        end else begin
            repeat (stall) begin @(posedge clk); #1; end
            cif.sample_valid = 1'b0;
            drop_cyc = cyc;
            guard = 0;
            while (n_done == 0 && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 200) timed_out = 1'b1;
        end
    endtask

    task automatic test_reset();
        int d;
        #1;
        tests++;
        if ({cif.cfg_ready, cif.busy, cif.done, cif.cfg_err,
             cif.frac_wr_en, cif.iir1_wr_en, cif.iir2_wr_en} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {cif.cfg_ready, cif.busy, cif.done, cif.cfg_err,
                      cif.frac_wr_en, cif.iir1_wr_en, cif.iir2_wr_en});
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        // Reset asserted in the middle of a frac load
        cif.cfg_start = 1'b1; cif.cfg_target = 2'd0;
        @(posedge clk); #1;
        cif.cfg_start = 1'b0; cif.cfg_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cif.cfg_data = CW'($urandom_range(1, 1000));
            @(posedge clk); #1;
        end
        d = count_diffs();
        tests++;
        if (d == 0 || cif.busy !== 1'b1) begin
            fails++;
            $display("FAIL midload_capture: diffs=%0d busy=%b want diffs>0 busy=1", d, cif.busy);
        end
        #2 rst = 1'b1;
        #1;
        d = count_diffs();
        tests++;
        if (d != 0 || {cif.cfg_ready, cif.busy, cif.done, cif.cfg_err} !== 4'b0) begin
            fails++;
            $display("FAIL reset_midload: diffs=%0d rdy/busy/done/err=%b want 0/0000", d,
                     {cif.cfg_ready, cif.busy, cif.done, cif.cfg_err});
        end
        cif.cfg_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_iir1_load();
        clear_mon();
        run_load(2'd1, 0, 0, 1'b0, -1, 1'b1);
        tests++;
        if (timed_out || n_wr[1] != 1 || n_wr[0] != 0 || n_wr[2] != 0 || n_done != 1) begin
            fails++;
            $display("FAIL iir1_strobes: to=%0d wr=%0d/%0d/%0d done=%0d want 0 0/1/0 1",
                     timed_out, n_wr[0], n_wr[1], n_wr[2], n_done);
        end
        tests++;
        if (done_cyc != wr_cyc[1] + WR2DONE) begin
            fails++;
            $display("FAIL iir1_done_after_wr: done@%0d wr@%0d want gap %0d", done_cyc, wr_cyc[1], WR2DONE);
        end
        tests++;
        if (done_cyc - start_cyc != 7 + WR2DONE) begin
            fails++;
            $display("FAIL iir1_latency: got %0d want %0d", done_cyc - start_cyc, 7 + WR2DONE);
        end
        tests++;
        if (count_diffs() != 0 || cif.iir1_coeff[0] !== CW'(1) || cif.iir1_coeff[4] !== CW'(5)) begin
            fails++;
            $display("FAIL iir1_shadow: diffs=%0d c0=%0d c4=%0d want 0 1 5",
                     count_diffs(), cif.iir1_coeff[0], cif.iir1_coeff[4]);
        end
    endtask

    task automatic test_frac_gaps();
        clear_mon();
        run_load(2'd0, 50, 0, 1'b0, -1, 1'b0);
        tests++;
        if (timed_out || n_wr[0] != 1 || n_wr[1] + n_wr[2] != 0 || n_done != 1) begin
            fails++;
            $display("FAIL frac_strobes: to=%0d wr=%0d/%0d/%0d done=%0d want 0 1/0/0 1",
                     timed_out, n_wr[0], n_wr[1], n_wr[2], n_done);
        end
        tests++;
        if (wr_cyc[0] != last_hs_cyc + 1) begin
            fails++;
            $display("FAIL frac_wr_timing: wr@%0d want %0d", wr_cyc[0], last_hs_cyc + 1);
        end
        tests++;
        if (count_diffs() != 0) begin
            fails++;
            $display("FAIL frac_shadow: diffs=%0d want 0", count_diffs());
        end
    endtask

    task automatic test_stall();
        clear_mon();
        run_load(2'd2, 20, 20, 1'b0, -1, 1'b0);
        tests++;
        if (timed_out || n_wr[2] != 1 || n_wr[0] + n_wr[1] != 0) begin
            fails++;
            $display("FAIL stall_strobes: to=%0d wr=%0d/%0d/%0d want 0 0/0/1",
                     timed_out, n_wr[0], n_wr[1], n_wr[2]);
        end
        tests++;
        if (wr_cyc[2] != drop_cyc + 1 || done_cyc != drop_cyc + 1 + WR2DONE) begin
            fails++;
            $display("FAIL stall_release: wr@%0d done@%0d want %0d %0d",
                     wr_cyc[2], done_cyc, drop_cyc + 1, drop_cyc + 1 + WR2DONE);
        end
        tests++;
        if (count_diffs() != 0) begin
            fails++;
            $display("FAIL stall_shadow: diffs=%0d want 0", count_diffs());
        end
    endtask

    task automatic test_errors();
        clear_mon();
        cif.cfg_start = 1'b1; cif.cfg_target = 2'd3;
        @(posedge clk); #1;
        cif.cfg_start = 1'b0;
        tests++;
        if (cif.cfg_err !== 1'b1 || cif.busy !== 1'b0 || cif.cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL illegal_target: err=%b busy=%b rdy=%b want 1 0 0",
                     cif.cfg_err, cif.busy, cif.cfg_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (cif.cfg_err !== 1'b0 || cif.busy !== 1'b0) begin
            fails++;
            $display("FAIL err_pulse_width: err=%b busy=%b want 0 0", cif.cfg_err, cif.busy);
        end
        clear_mon();
        run_load(2'd1, 30, 0, 1'b1, -1, 1'b0);
        tests++;
        if (timed_out || n_err != 1 || n_wr[1] != 1 || n_done != 1 || count_diffs() != 0) begin
            fails++;
            $display("FAIL start_while_busy: to=%0d err=%0d wr=%0d done=%0d diffs=%0d want 0 1 1 1 0",
                     timed_out, n_err, n_wr[1], n_done, count_diffs());
        end
    endtask

    task automatic test_abort();
        clear_mon();
        run_load(2'd2, 0, 0, 1'b0, 3, 1'b0);
        tests++;
        if (n_wr[2] != 0 || n_done != 0 || cif.busy !== 1'b0 || cif.cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: wr=%0d done=%0d busy=%b rdy=%b want 0 0 0 0",
                     n_wr[2], n_done, cif.busy, cif.cfg_ready);
        end
        tests++;
        if (count_diffs() != 0) begin
            fails++;
            $display("FAIL abort_partial_shadow: diffs=%0d want 0", count_diffs());
        end
        clear_mon();
        run_load(2'd2, 10, 2, 1'b0, -1, 1'b0);
        tests++;
        if (timed_out || n_wr[2] != 1 || n_done != 1 || count_diffs() != 0) begin
            fails++;
            $display("FAIL reload_after_abort: to=%0d wr=%0d done=%0d diffs=%0d want 0 1 1 0",
                     timed_out, n_wr[2], n_done, count_diffs());
        end
    endtask

    task automatic test_random();
        logic [1:0] tgt;
        int stall;
        for (int k = 0; k < 8; k++) begin
            tgt = 2'($urandom_range(2));
            stall = $urandom_range(5);
            clear_mon();
            run_load(tgt, $urandom_range(70), stall, 1'b0, -1, 1'b0);
            tests++;
            if (timed_out || n_wr[tgt] != 1 || n_wr[0] + n_wr[1] + n_wr[2] != 1 || n_done != 1
                || wr_cyc[tgt] != drop_cyc + 1 || done_cyc != wr_cyc[tgt] + WR2DONE
                || count_diffs() != 0) begin
                fails++;
                $display("FAIL random_load[%0d]: tgt=%0d to=%0d wr=%0d/%0d/%0d done=%0d wr@%0d want@%0d diffs=%0d",
                         k, tgt, timed_out, n_wr[0], n_wr[1], n_wr[2], n_done,
                         wr_cyc[tgt], drop_cyc + 1, count_diffs());
            end
        end
`ifdef DFE_COEFF_READBACK_CHECK_EN
        tests++;
        if (cif.chk_err !== 1'b0) begin
            fails++;
            $display("FAIL chk_err: got %b want 0", cif.chk_err);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        cif.cfg_start = 1'b0;
        cif.cfg_target = 2'd0;
        cif.cfg_abort = 1'b0;
        cif.cfg_valid = 1'b0;
        cif.cfg_data = '0;
        cif.sample_valid = 1'b0;
        for (int i = 0; i < NF; i++) exp_frac[i] = '0;
        for (int i = 0; i < NI; i++) begin exp_i1[i] = '0; exp_i2[i] = '0; end
`ifdef DFE_COEFF_READBACK_CHECK_EN
        for (int i = 0; i < NF; i++) cif.frac_coeff_rb[i] = '0;
        for (int i = 0; i < NI; i++) begin cif.iir1_coeff_rb[i] = '0; cif.iir2_coeff_rb[i] = '0; end
`endif
        clear_mon();
        test_reset();
        test_iir1_load();
        test_frac_gaps();
        test_stall();
        test_errors();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end
endmodule
